// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets NUM_SRC AXI-Stream byte sources share one UART transmitter, packet by packet.
// Latency: grant 1 cycle after a request is seen in IDLE; tx_start 1 cycle after a byte is accepted.
// Backpressure: only the granted source sees s_tready, in SEND while tx_busy is low; one byte per frame, no buffering.
// Optional: define UART_ARB_ID_EN to send the granted source index as a header byte ahead of each packet.
module uart_tx_arb #(
    parameter int NUM_SRC   = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC*DATA_BITS-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]           s_tvalid,
    input  logic [NUM_SRC-1:0]           s_tlast,
    output logic [NUM_SRC-1:0]           s_tready,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic                         tx_start,
    input  logic                         tx_busy,
    output logic [NUM_SRC-1:0]           grant,
    output logic                         arb_busy
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
`ifdef UART_ARB_ID_EN
        , ST_ID = 2'd3
`endif
    } state_t;

    state_t               state, state_nxt;
    logic [NUM_SRC-1:0]   grant_nxt;
    logic [IDX_W-1:0]     last_gnt, last_gnt_nxt;
    logic [DATA_BITS-1:0] tx_data_nxt;
    logic                 tx_start_nxt;
    // High on the first WAIT cycle, when tx_busy has not yet had a chance to rise.
    logic                 wait_first, wait_first_nxt;
    // The byte just handed to the transmitter closed its packet.
    logic                 pkt_end, pkt_end_nxt;

    logic [NUM_SRC-1:0]   rr_onehot;
    logic [IDX_W-1:0]     rr_idx;
    logic                 rr_found;
    int                   rr_dist;
    int                   rr_best;

    logic [IDX_W-1:0]     g_idx;
    logic [DATA_BITS-1:0] g_byte;
    logic                 g_last;
    logic                 xfer;

    // Round-robin pick: the requester closest after last_gnt in circular order wins.
    always_comb begin
        rr_found  = 1'b0;
        rr_idx    = '0;
        rr_best   = NUM_SRC;
        rr_dist   = 0;
        rr_onehot = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            rr_dist = (j + NUM_SRC - 1 - int'(last_gnt)) % NUM_SRC;
            if (s_tvalid[j] && (rr_dist < rr_best)) begin
                rr_best  = rr_dist;
                rr_idx   = IDX_W'(j);
                rr_found = 1'b1;
            end
        end
        for (int j = 0; j < NUM_SRC; j++) begin
            rr_onehot[j] = rr_found && (rr_idx == IDX_W'(j));
        end
    end

    // Select the index, byte and last flag of the current owner.
    always_comb begin
        g_idx  = '0;
        g_byte = '0;
        g_last = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (grant[j]) begin
                g_idx  = IDX_W'(j);
                g_byte = s_tdata[j*DATA_BITS +: DATA_BITS];
                g_last = s_tlast[j];
            end
        end
    end

    assign s_tready = ((state == ST_SEND) && !tx_busy) ? grant : '0;
    assign xfer     = |(s_tvalid & s_tready);
    assign arb_busy = (state != ST_IDLE);

    // Next-state and next-output logic of the packet sequencer.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_gnt_nxt   = last_gnt;
        tx_data_nxt    = tx_data;
        tx_start_nxt   = 1'b0;
        wait_first_nxt = 1'b0;
        pkt_end_nxt    = pkt_end;
        case (state)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_nxt = rr_onehot;
`ifdef UART_ARB_ID_EN
                    state_nxt = ST_ID;
`else
                    state_nxt = ST_SEND;
`endif
                end
            end
`ifdef UART_ARB_ID_EN
            ST_ID: begin
                // Header byte: owner index, zero-extended; no source byte is consumed.
                if (!tx_busy) begin
                    tx_data_nxt    = DATA_BITS'(g_idx);
                    tx_start_nxt   = 1'b1;
                    wait_first_nxt = 1'b1;
                    pkt_end_nxt    = 1'b0;
                    state_nxt      = ST_WAIT;
                end
            end
`endif
            ST_SEND: begin
                if (xfer) begin
                    tx_data_nxt    = g_byte;
                    tx_start_nxt   = 1'b1;
                    wait_first_nxt = 1'b1;
                    pkt_end_nxt    = g_last;
                    state_nxt      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!wait_first && !tx_busy) begin
                    if (pkt_end) begin
                        state_nxt    = ST_IDLE;
                        grant_nxt    = '0;
                        last_gnt_nxt = g_idx;
                    end else begin
                        state_nxt = ST_SEND;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_gnt   <= IDX_W'(NUM_SRC - 1);
            tx_data    <= '0;
            tx_start   <= 1'b0;
            wait_first <= 1'b0;
            pkt_end    <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_gnt   <= last_gnt_nxt;
            tx_data    <= tx_data_nxt;
            tx_start   <= tx_start_nxt;
            wait_first <= wait_first_nxt;
            pkt_end    <= pkt_end_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: per-source byte queues, a UART busy model and directed checks.
// Latency: n/a (testbench).
// Backpressure: sources hold a byte until it is accepted; hold[] can pause a source.
module tb_uart_tx_arb;
    localparam int N        = 4;
    localparam int D        = 8;
    localparam int BUSY_LEN = 10;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] exp_grant;
        logic [D-1:0] exp_byte;
        logic [D-1:0] exp_id;
    } vec_t;

    logic         clk        = 1'b0;
    logic         rst        = 1'b1;
    logic [N*D-1:0] s_tdata  = '0;
    logic [N-1:0] s_tvalid   = '0;
    logic [N-1:0] s_tlast    = '0;
    logic [N-1:0] s_tready;
    logic [D-1:0] tx_data;
    logic         tx_start;
    logic         tx_busy;
    logic [N-1:0] grant;
    logic         arb_busy;

    logic         force_busy = 1'b0;
    int           busy_cnt   = 0;
    logic [N-1:0] hold       = '0;
    logic [8:0]   srcq [N][$];
    int           acc_cnt [N] = '{default: 0};
    int           n_tests    = 0;
    int           n_fail     = 0;

    uart_tx_arb #(.NUM_SRC(N), .DATA_BITS(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .grant    (grant),
        .arb_busy (arb_busy)
    );

    always #5 clk = ~clk;

    // UART model: busy rises the cycle after tx_start and lasts BUSY_LEN cycles.
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || force_busy;

    // Source driver: note accepts mid-cycle, pop them and present queue heads after the edge.
    always begin : src_drv
        logic [N-1:0]   acc;
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [N*D-1:0] d;
        @(negedge clk);
        acc = s_tvalid & s_tready & {N{~rst}};
        @(posedge clk);
        #1;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                acc_cnt[i]++;
                if (srcq[i].size() > 0) void'(srcq[i].pop_front());
            end
            if (srcq[i].size() > 0 && !hold[i]) begin
                v[i]         = 1'b1;
                l[i]         = srcq[i][0][8];
                d[i*D +: D]  = srcq[i][0][7:0];
            end
        end
        s_tvalid = v;
        s_tlast  = l;
        s_tdata  = d;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    task automatic wait_grant(input string name);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (grant != '0) return;
        end
        timeout(name);
    endtask

    task automatic expect_tx(input string name, input logic [D-1:0] exp_byte,
                             input logic [N-1:0] exp_grant, output int cyc);
        cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (tx_start) begin
                cyc = c;
                check({name, ".data"}, 32'(tx_data), 32'(exp_byte));
                check({name, ".grant"}, 32'(grant), 32'(exp_grant));
                return;
            end
        end
        timeout(name);
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (!arb_busy) begin
                check({name, ".grant0"}, 32'(grant), 32'd0);
                return;
            end
        end
        timeout(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) srcq[i].delete();
        hold       = '0;
        force_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20 && tx_busy; c++) @(negedge clk);
    endtask

    vec_t tbl [8];

    initial begin : main
        int cyc;
        int viol;
        int base;

        tbl[0] = '{4'b1111, 4'b0001, 8'h00, 8'h00};
        tbl[1] = '{4'b1111, 4'b0010, 8'h11, 8'h01};
        tbl[2] = '{4'b1001, 4'b1000, 8'h23, 8'h03};
        tbl[3] = '{4'b1001, 4'b0001, 8'h30, 8'h00};
        tbl[4] = '{4'b0001, 4'b0001, 8'h40, 8'h00};
        tbl[5] = '{4'b0100, 4'b0100, 8'h52, 8'h02};
        tbl[6] = '{4'b1011, 4'b1000, 8'h63, 8'h03};
        tbl[7] = '{4'b0110, 4'b0010, 8'h71, 8'h01};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.grant",    32'(grant),    32'd0);
        check("rst.tx_start", 32'(tx_start), 32'd0);
        check("rst.tx_data",  32'(tx_data),  32'd0);
        check("rst.s_tready", 32'(s_tready), 32'd0);
        check("rst.arb_busy", 32'(arb_busy), 32'd0);
        rst = 1'b0;

        // Round-robin table: single-byte packets from the listed requesters
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++)
                if (tbl[k].req[i]) srcq[i].push_back({1'b1, 4'(k), 4'(i)});
            wait_grant($sformatf("rr%0d", k));
            check($sformatf("rr%0d.grant", k), 32'(grant), 32'(tbl[k].exp_grant));
            check($sformatf("rr%0d.busy", k), 32'(arb_busy), 32'd1);
`ifdef UART_ARB_ID_EN
            expect_tx($sformatf("rr%0d.id", k), tbl[k].exp_id, tbl[k].exp_grant, cyc);
`endif
            expect_tx($sformatf("rr%0d.tx", k), tbl[k].exp_byte, tbl[k].exp_grant, cyc);
            for (int i = 0; i < N; i++) srcq[i].delete();
            wait_idle($sformatf("rr%0d.idle", k));
        end

`ifndef UART_ARB_ID_EN
        // Two-byte packet from source 2 with a 10-cycle frame
        do_reset();
        base = acc_cnt[2];
        srcq[2].push_back(9'h041);
        srcq[2].push_back(9'h142);
        wait_grant("pkt2");
        check("pkt2.grant", 32'(grant), 32'b0100);
        expect_tx("pkt2.b0", 8'h41, 4'b0100, cyc);
        @(negedge clk);
        check("pkt2.pulse", 32'(tx_start), 32'd0);
        check("pkt2.held", 32'(grant), 32'b0100);
        expect_tx("pkt2.b1", 8'h42, 4'b0100, cyc);
        check("pkt2.gap", 32'(cyc), 32'd12);
        @(negedge clk);
        check("pkt2.pulse2", 32'(tx_start), 32'd0);
        wait_idle("pkt2.idle");
        check("pkt2.acks", 32'(acc_cnt[2] - base), 32'd2);

        // Sources 0 and 1 requesting continuously alternate
        do_reset();
        for (int p = 0; p < 3; p++) begin
            srcq[0].push_back({1'b1, 8'(8'hA0 + 8'(p))});
            srcq[1].push_back({1'b1, 8'(8'hB0 + 8'(p))});
        end
        for (int p = 0; p < 3; p++) begin
            expect_tx($sformatf("alt.s0_%0d", p), 8'(8'hA0 + 8'(p)), 4'b0001, cyc);
            expect_tx($sformatf("alt.s1_%0d", p), 8'(8'hB0 + 8'(p)), 4'b0010, cyc);
        end
        wait_idle("alt.idle");

        // Source 3 stalls mid-packet; source 0 must stay blocked
        do_reset();
        srcq[3].push_back(9'h031);
        srcq[3].push_back(9'h032);
        srcq[3].push_back(9'h133);
        wait_grant("stall");
        check("stall.grant", 32'(grant), 32'b1000);
        srcq[0].push_back(9'h10A);
        expect_tx("stall.b0", 8'h31, 4'b1000, cyc);
        hold[3] = 1'b1;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_tready[0] || tx_start || (grant != 4'b1000)) viol++;
        end
        check("stall.blocked", 32'(viol), 32'd0);
        hold[3] = 1'b0;
        expect_tx("stall.b1", 8'h32, 4'b1000, cyc);
        expect_tx("stall.b2", 8'h33, 4'b1000, cyc);
        expect_tx("stall.s0", 8'h0A, 4'b0001, cyc);
        wait_idle("stall.idle");

        // Reset during WAIT of byte 2 of a 4-byte packet (last owner was source 0)
        base = acc_cnt[1];
        srcq[1].push_back(9'h061);
        srcq[1].push_back(9'h062);
        srcq[1].push_back(9'h063);
        srcq[1].push_back(9'h164);
        expect_tx("abort.b0", 8'h61, 4'b0010, cyc);
        expect_tx("abort.b1", 8'h62, 4'b0010, cyc);
        rst = 1'b1;
        srcq[1].delete();
        @(negedge clk);
        check("abort.grant",    32'(grant),    32'd0);
        check("abort.tx_start", 32'(tx_start), 32'd0);
        check("abort.arb_busy", 32'(arb_busy), 32'd0);
        check("abort.s_tready", 32'(s_tready), 32'd0);
        rst = 1'b0;
        check("abort.acks", 32'(acc_cnt[1] - base), 32'd2);
        srcq[0].push_back(9'h10C);
        srcq[3].push_back(9'h13C);
        wait_grant("abort.rearb");
        check("abort.rearb.grant", 32'(grant), 32'b0001);
        expect_tx("abort.s0", 8'h0C, 4'b0001, cyc);
        expect_tx("abort.s3", 8'h3C, 4'b1000, cyc);
        wait_idle("abort.idle");

        // Transmitter busy before the grant: no s_tready until it drops
        force_busy = 1'b1;
        srcq[2].push_back(9'h177);
        viol = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_tready != '0 || tx_start) viol++;
        end
        check("busy.no_rdy", 32'(viol), 32'd0);
        check("busy.grant", 32'(grant), 32'b0100);
        @(posedge clk);
        #1;
        force_busy = 1'b0;
        @(negedge clk);
        check("busy.rdy", 32'(s_tready), 32'b0100);
        expect_tx("busy.tx", 8'h77, 4'b0100, cyc);
        check("busy.first_low", 32'(cyc), 32'd1);
        wait_idle("busy.idle");
`else
        // Header byte carries the owner index ahead of the packet
        do_reset();
        base = acc_cnt[1];
        srcq[1].push_back(9'h155);
        wait_grant("id");
        check("id.grant", 32'(grant), 32'b0010);
        expect_tx("id.hdr", 8'h01, 4'b0010, cyc);
        expect_tx("id.byte", 8'h55, 4'b0010, cyc);
        wait_idle("id.idle");
        check("id.acks", 32'(acc_cnt[1] - base), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog in case a wait loop itself stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
- REQ-001: Parameter NUM_SRC, default 4; number of AXI-Stream byte sources (1..8).
- REQ-002: Parameter DATA_BITS, default 8; byte width, matching the UART transmitter.
- REQ-003: clk  input  1  single clock; all logic on rising edge.
- REQ-004: rst  input  1  reset; synchronous and active-high.
- REQ-005: s_tdata  input  NUM_SRC*DATA_BITS  source bytes; source i occupies bits [i*DATA_BITS +: DATA_BITS].
- REQ-006: s_tvalid  input  NUM_SRC  per-source byte valid.
- REQ-007: s_tlast  input  NUM_SRC  per-source last byte of packet.
- REQ-008: s_tready  output  NUM_SRC  per-source byte accept.
- REQ-009: tx_data  output  DATA_BITS  byte to the UART transmitter.
- REQ-010: tx_start  output  1  one-cycle transmit strobe.
- REQ-011: tx_busy  input  1  transmitter busy; rises the cycle after tx_start and stays high until the frame is done.
- REQ-012: grant  output  NUM_SRC  one-hot owner of the transmitter; all-zero when idle.
- REQ-013: arb_busy  output  1  high whenever state is not IDLE.

Function
- REQ-014: States SHALL be IDLE, ID (only when UART_ARB_ID_EN is defined), SEND, and WAIT.
- REQ-015: IDLE: if any s_tvalid is high, the round-robin winner SHALL be registered into grant; the next state is ID if enabled, else SEND; grant is visible 1 cycle after s_tvalid is sampled.
- REQ-016: Round-robin: search starts at (last_granted+1) mod NUM_SRC and takes the first requesting index; after reset, last_granted = NUM_SRC-1, so source 0 has first priority.
- REQ-017: s_tready[i] SHALL be combinational: (state==SEND) && grant[i] && !tx_busy; all other bits are 0.
- REQ-018: A byte transfers on a cycle with s_tvalid[g] && s_tready[g]; on that edge tx_data <= byte, tx_start <= 1 for exactly one cycle, and the state becomes WAIT.
- REQ-019: WAIT SHALL ignore tx_busy on its first cycle, then return to SEND when tx_busy == 0.
- REQ-020: On return from WAIT, if the transferred byte had s_tlast high, the state SHALL go to IDLE instead; grant clears and last_granted is updated in the same edge.
- REQ-021: Grant SHALL be held for the whole packet; if s_tvalid[g] drops mid-packet, the block waits in SEND indefinitely and other sources stay blocked.
- REQ-022: Requests from non-granted sources during a packet are ignored; they are arbitrated at the next IDLE.
- REQ-023: If the same single source requests continuously, it SHALL be re-granted after one IDLE cycle between packets.
- REQ-024: Throughput: at most one byte per transmitter frame; no internal byte buffering.
- REQ-025: NUM_SRC == 1 SHALL degenerate to a pass-through sequencer with grant == 1 while active.

Reset
- REQ-026: On rst, the block SHALL set state=IDLE, grant=0, tx_start=0, tx_data=0, s_tready=0, arb_busy=0, and last_granted=NUM_SRC-1.
- REQ-027: Reset mid-packet SHALL abandon the packet with no further tx_start; the source is not acknowledged for the pending byte.

Configuration
- REQ-028: Macro UART_ARB_ID_EN, when defined, SHALL add state ID: on entry, when tx_busy == 0, send tx_data = zero-extended grant index with one tx_start, then WAIT, then SEND; no source byte is consumed.
- REQ-029: Without UART_ARB_ID_EN, state ID is absent and IDLE goes directly to SEND.

Verification
- REQ-030: Source 2 sends packet 0x41,0x42 (tlast on 0x42), tx_busy modelled for 10 cycles per byte -> tx_data 0x41 then 0x42, two single-cycle tx_start pulses, grant = 4'b0100 throughout, then 0.
- REQ-031: Sources 0 and 1 both request 1-byte packets continuously, out of reset -> grant order 0,1,0,1; no source is granted twice in a row.
- REQ-032: Source 3 drops s_tvalid for 20 cycles mid-packet while source 0 requests -> source 0 gets no s_tready; source 3 completes, then source 0 is granted.
- REQ-033: rst asserted during WAIT of the 2nd byte of a 4-byte packet -> next cycle grant=0, tx_start=0, arb_busy=0; the next arbitration starts from source 0.
- REQ-034: With UART_ARB_ID_EN, source 1 sends 0x55 with tlast -> transmitted bytes are 0x01 then 0x55; s_tready[1] pulses exactly once.
- REQ-035: tx_busy held high for 5 cycles before a grant -> s_tready stays 0 until tx_busy is low; the first byte then transfers on the first low cycle.
